// File: rtl/time_set_ctrl.sv
// time_set_ctrl: debounced front-panel editor producing BCD hh:mm init values and a load strobe
module time_set_ctrl #(
  parameter int DEBOUNCE_CNT = 10000,
  parameter int CNT_W = 14
) (
  input  logic       CLK100MHZ,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] hourdec_init,
  output logic [3:0] hourone_init,
  output logic [3:0] mindec_init,
  output logic [3:0] minone_init,
  output logic       load,
  output logic       edit_active,
  output logic       edit_field
);
  typedef enum logic [1:0] {IDLE, EDIT_HOUR, EDIT_MIN, COMMIT} state_t;
  state_t state, nxt;
  logic [2:0] raw, press;
  logic [3:0] w_hd, w_ho, w_md, w_mo;
  logic p_mode, p_up, p_down, adj_up, adj_dn;
  logic [7:0] hour_nxt, min_nxt;
  assign raw = {btn_down, btn_up, btn_mode};
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [1:0] sync;
    logic [CNT_W-1:0] cnt;
    logic lvl, pulse;
    always_ff @(posedge CLK100MHZ)
      if (rst) begin
        sync <= '0;
        cnt <= '0;
        lvl <= 1'b0;
        pulse <= 1'b0;
      end else begin
        sync <= {sync[0], raw[i]};
        pulse <= 1'b0;
        if (sync[1] == lvl) cnt <= '0;
        else if (cnt == CNT_W'(DEBOUNCE_CNT)) begin
          cnt <= '0;
          lvl <= sync[1];
          pulse <= sync[1];
        end else cnt <= cnt + 1'b1;
      end
    assign press[i] = pulse;
  end
  assign {p_down, p_up, p_mode} = press;
  // mode wins over adjust; up and down together cancel
  assign adj_up = p_up & ~p_down & ~p_mode;
  assign adj_dn = p_down & ~p_up & ~p_mode;
  function automatic logic [7:0] inc(input logic [7:0] v, input logic [7:0] mx);
    return v == mx ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
  function automatic logic [7:0] dec(input logic [7:0] v, input logic [7:0] mx);
    return v == 8'h00 ? mx : v[3:0] == 4'd0 ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction
  assign hour_nxt = adj_up ? inc({w_hd, w_ho}, 8'h23) : dec({w_hd, w_ho}, 8'h23);
  assign min_nxt = adj_up ? inc({w_md, w_mo}, 8'h59) : dec({w_md, w_mo}, 8'h59);
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (p_mode ? EDIT_HOUR : IDLE) :
          state == EDIT_HOUR ? (p_mode ? EDIT_MIN : EDIT_HOUR) :
          state == EDIT_MIN ? (p_mode ? COMMIT : EDIT_MIN) : IDLE;
  end
  always_ff @(posedge CLK100MHZ)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge CLK100MHZ)
    if (rst) begin
      {hourdec_init, hourone_init, mindec_init, minone_init} <= '0;
      {w_hd, w_ho, w_md, w_mo} <= '0;
      load <= 1'b0;
      edit_active <= 1'b0;
      edit_field <= 1'b0;
    end else begin
      load <= state == COMMIT;
      edit_active <= nxt == EDIT_HOUR || nxt == EDIT_MIN;
      edit_field <= nxt == EDIT_MIN;
      if (state == IDLE && p_mode) {w_hd, w_ho, w_md, w_mo} <= {hourdec_init, hourone_init, mindec_init, minone_init};
      if (state == EDIT_HOUR && (adj_up || adj_dn)) {w_hd, w_ho} <= hour_nxt;
      if (state == EDIT_MIN && (adj_up || adj_dn)) {w_md, w_mo} <= min_nxt;
      if (state == COMMIT) {hourdec_init, hourone_init, mindec_init, minone_init} <= {w_hd, w_ho, w_md, w_mo};
    end
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: scoreboard bench; expected commits queued at the final mode press, checked on load
module tb_time_set_ctrl;
  logic clk = 0, rst = 1, bm = 0, bu = 0, bd = 0;
  logic [3:0] hd, ho, md, mo;
  logic load, edit_active, edit_field;
  int total = 0, bad = 0, loads = 0, exp_loads = 0;
  int mh = 0, mm = 0, st = 0, lat;
  logic [15:0] sb[$];
  always #5 clk = ~clk;
  time_set_ctrl #(.DEBOUNCE_CNT(4), .CNT_W(14)) dut (
    .CLK100MHZ(clk), .rst(rst), .btn_mode(bm), .btn_up(bu), .btn_down(bd),
    .hourdec_init(hd), .hourone_init(ho), .mindec_init(md), .minone_init(mo),
    .load(load), .edit_active(edit_active), .edit_field(edit_field)
  );
  wire [15:0] outs = {hd, ho, md, mo};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] bcd(input int h, input int m);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction
  always @(negedge clk)
    if (load) begin
      loads++;
      if (sb.size() == 0) check("load_unexpected", 1, 0);
      else check("commit", outs, sb.pop_front());
    end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic hit(input logic m, input logic u, input logic d);
    bm = m; bu = u; bd = d;
    cyc(10);
    bm = 0; bu = 0; bd = 0;
    cyc(10);
  endtask
  task automatic up(input int n);
    repeat (n) begin
      hit(0, 1, 0);
      if (st == 1) mh = (mh + 1) % 24; else mm = (mm + 1) % 60;
    end
  endtask
  task automatic down(input int n);
    repeat (n) begin
      hit(0, 0, 1);
      if (st == 1) mh = (mh + 23) % 24; else mm = (mm + 59) % 60;
    end
  endtask
  task automatic stage();
    if (st == 2) begin
      sb.push_back(bcd(mh, mm));
      exp_loads++;
      st = 0;
    end else st++;
    hit(1, 0, 0);
    check("edit_active", edit_active, st != 0);
    check("edit_field", edit_field, st == 2);
  endtask
  initial begin
    cyc(3);
    rst = 0;
    cyc(50);
    check("rst_outs", outs, 16'h0000);
    check("rst_load", load, 0);
    check("rst_active", edit_active, 0);
    check("rst_field", edit_field, 0);
    bm = 1; cyc(3); bm = 0; cyc(20);
    check("glitch_mode", edit_active, 0);
    bu = 1; cyc(20); bu = 0; cyc(10);
    check("idle_up_outs", outs, 16'h0000);
    check("idle_up_active", edit_active, 0);
    lat = -1;
    bm = 1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (edit_active && lat < 0) lat = k;
    end
    bm = 0; cyc(10);
    st = 1;
    check("mode_latency", lat, 7);
    check("hour_field", edit_field, 0);
    up(25);
    stage();
    down(1);
    stage();
    check("loads_t3", loads, 1);
    stage(); up(18); up(1); stage(); stage();
    stage(); down(1); stage(); stage();
    stage(); stage();
    hit(0, 1, 1);
    check("both_active", edit_active, 1);
    sb.push_back(bcd(mh, mm));
    exp_loads++;
    st = 0;
    hit(1, 1, 0);
    check("mode_up_active", edit_active, 0);
    stage(); down(7); stage(); down(25);
    check("pre_rst_field", edit_field, 1);
    rst = 1; cyc(1); rst = 0;
    mh = 0; mm = 0; st = 0;
    check("mid_rst_outs", outs, 16'h0000);
    check("mid_rst_active", edit_active, 0);
    check("mid_rst_field", edit_field, 0);
    check("mid_rst_load", load, 0);
    cyc(10);
    stage(); stage(); stage();
    cyc(5);
    check("load_count", loads, exp_loads);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Front-panel time-entry controller for the Arty-A7 alarm-clock design. It debounces the raw push-buttons and runs a small editing state machine over BCD hours and minutes. It drives the `hourdec_init`/`hourone_init`/`mindec_init`/`minone_init` bus and a one-cycle `load` strobe into the watch core, replacing the constant-zero init tie-off. It is the input side of the watch's time interface; the seven-segment driver is the output side.

## Interface
- `DEBOUNCE_CNT`, default 10000: consecutive stable cycles required before a button level is accepted (100 µs at 100 MHz).
- `CNT_W`, default 14: width of each debounce counter; must hold `DEBOUNCE_CNT`.

Ports:
- `CLK100MHZ`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous reset, active-high.
- `btn_mode`  in  1  raw asynchronous button: advance the edit stage.
- `btn_up`  in  1  raw asynchronous button: increment the selected field.
- `btn_down`  in  1  raw asynchronous button: decrement the selected field.
- `hourdec_init`  out  4  committed hours tens digit, BCD 0..2.
- `hourone_init`  out  4  committed hours units digit, BCD 0..9.
- `mindec_init`  out  4  committed minutes tens digit, BCD 0..5.
- `minone_init`  out  4  committed minutes units digit, BCD 0..9.
- `load`  out  1  one-cycle strobe; the watch core reloads from the init bus.
- `edit_active`  out  1  high while in EDIT_HOUR or EDIT_MIN.
- `edit_field`  out  1  0 = hours selected, 1 = minutes selected; used by the display for blinking.

## Operation
**Button conditioning**
- Each button has its own 2-flop synchronizer, `CNT_W`-bit stability counter, debounced-level register and press-edge register.
- The counter clears whenever the synchronized level equals the debounced level. Otherwise it increments.
- When the counter reaches `DEBOUNCE_CNT`, the debounced level takes the synchronized value and the counter clears.
- A press pulse (`p_mode`, `p_up`, `p_down`) fires for exactly 1 cycle on each 0→1 transition of the debounced level.
- Release (1→0) produces no pulse.

**Data path**
- Working registers `w_hd`, `w_ho`, `w_md`, `w_mo` hold the value being edited.
- Hours wrap within 00..23:
  - Increment: 23→00; units 9→0 with a tens carry; otherwise units+1.
  - Decrement: 00→23; units 0→9 with a tens borrow; otherwise units−1.
- Minutes wrap within 00..59 using the same rules: 59→00 and 00→59.
- The outputs are committed copies of the working registers. They change only in COMMIT.

**FSM**
- IDLE:
  - `p_mode` → EDIT_HOUR, and the working registers are loaded from the current outputs.
  - `p_up` and `p_down` are ignored.
- EDIT_HOUR:
  - `p_up` or `p_down` adjusts the hours.
  - `p_mode` → EDIT_MIN.
- EDIT_MIN:
  - `p_up` or `p_down` adjusts the minutes.
  - `p_mode` → COMMIT.
- COMMIT:
  - Outputs ← working registers, `load`=1.
  - Unconditionally → IDLE on the next cycle.
- Simultaneous events:
  - `p_up` and `p_down` in the same cycle: neither is applied.
  - `p_mode` together with `p_up` or `p_down`: the state transition is taken and the adjust is dropped.
  - Any press pulse during COMMIT is dropped.

## Timing
- Reset values:
  - State IDLE.
  - All four outputs 0 (time 00:00).
  - `load`=0, `edit_active`=0, `edit_field`=0.
  - Working registers 0, debounce counters 0, debounced levels 0, synchronizers 0.
- Latency from the first clock edge at which a raw button is sampled high (and held):
  - Debounced level high at edge +2+`DEBOUNCE_CNT`.
  - Press pulse high during the following cycle.
  - The resulting state or digit register updates on the edge ending that pulse cycle.
- A glitch shorter than `DEBOUNCE_CNT` synchronized cycles produces no pulse; the counter restarts on any bounce.
- `load` is high for exactly 1 cycle and coincides with the first cycle in which the new output values are visible.
- `edit_active` and `edit_field` are registered decodes of the state; they change in the same cycle as the state.
- `rst` in the middle of an edit:
  - Returns to IDLE and discards any uncommitted working values.
  - Outputs return to 00:00 and no `load` is issued.
  - Takes priority over every other event in that cycle.

## Test plan
Run all benches with `DEBOUNCE_CNT`=4.

1. Reset, then idle for 50 cycles.
   - Outputs 0,0,0,0; `load`=0; `edit_active`=0.
2. Hold `btn_up` for 3 cycles in IDLE, then hold it for 20 cycles.
   - No pulse from the 3-cycle press; its counter restarts.
   - The 20-cycle press gives its pulse at cycle +7, but outputs are unchanged because the FSM is in IDLE.
3. Press mode, press up ×25, press mode, press down ×1, press mode.
   - Hours wrap 23→00 then step to 01; minutes 00→59.
   - `load` pulses once; outputs read 0,1,5,9.
   - `edit_field` reads 0 then 1.
4. Enter EDIT_HOUR from 19:xx and press up once.
   - Hours become 20 (units carry into tens).
   - From 20, press down: hours become 19.
5. In EDIT_MIN, drive up and down to rise on the same cycle.
   - The minutes value is unchanged.
   - Then drive mode and up together: state moves to COMMIT and the minutes value is still unchanged.
6. Assert `rst` during EDIT_MIN after setting 12:34 in the working registers.
   - Returns to IDLE; outputs read 00:00; no `load` seen.
